// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one opcode at a time to a combinational ALU, holds the
// strobe for a per-op window (multicycle MUL/DIV), captures and returns the result.
module alu_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [12:0] alu_ctrl,
    input  logic [63:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        err_q, err_d;
    logic [12:0] ctrl_q, ctrl_d;
    logic        legal, wide;
    logic [7:0]  lat_m1;

    assign legal  = req_op <= 4'd12 && !(req_op == 4'd3 && req_b == 32'd0);
    assign wide   = op_q == 4'd2 || op_q == 4'd3;
    assign lat_m1 = req_op == 4'd2 ? 8'(MUL_CYCLES - 1) :
                    req_op == 4'd3 ? 8'(DIV_CYCLES - 1) : 8'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        ctrl_d  = ctrl_q;
        if (state_q == IDLE && req_valid) begin
            op_d = req_op;
            a_d  = req_a;
            b_d  = req_b;
            if (legal) begin
                state_d = EXEC;
                cnt_d   = lat_m1;
                ctrl_d  = 13'd1 << req_op;
            end else begin
                // rejected ops skip the ALU entirely and report a zero result
                state_d = RESP;
                err_d   = 1'b1;
                hi_d    = 32'd0;
                lo_d    = 32'd0;
            end
        end else if (state_q == EXEC) begin
            if (cnt_q == 8'd0) begin
                state_d = RESP;
                ctrl_d  = 13'd0;
                hi_d    = wide ? alu_out[63:32] : 32'd0;
                lo_d    = alu_out[31:0];
                err_d   = 1'b0;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            err_q   <= 1'b0;
            ctrl_q  <= 13'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign req_ready = clear_n && state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rsp_valid = state_q == RESP;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_ctrl  = ctrl_q;
    assign rsp_hi    = hi_q;
    assign rsp_lo    = lo_q;
    assign rsp_err   = err_q;
endmodule
